// File: rtl/sd_spi_shifter.sv
// sd_spi_shifter
// ---------------------------------------------------------------------------
// SPI-mode byte engine for an SD card behind an Avalon-MM slave port.
// The CPU writes a byte to DATA. The block shifts it out MSB-first in SPI
// mode 0 while capturing MISO. It then raises done and returns to idle.
// The SCLK half-period is (div+1) clk cycles, and div is programmable.
//
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   address[1:0]     0 DATA, 1 STATUS {done,busy}, 2 DIV, 3 reserved
//   chipselect       slave select
//   write_n, read_n  active-low strobes
//   writedata[31:0]  write data (only bits [7:0] are meaningful)
//   readdata[31:0]   combinational read data, zero wait states
//   sd_ncs_in        card chip select from the CS PIO
//   sd_cs_n          sd_ncs_in passed straight through to the card
//   sd_miso          card DO, sampled on SCLK rising edges
//   sd_sclk          SPI clock, idles low
//   sd_mosi          card DI, idles high
//
// Handshake: the slave never stalls. A write is accepted in any cycle with
// chipselect=1 and write_n=0. A read is accepted in any cycle with
// chipselect=1 and read_n=0. readdata is valid in that same cycle.
module sd_spi_shifter #(
  parameter logic [7:0] DIV_RESET = 8'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sd_ncs_in,
  input  logic        sd_miso,
  output logic        sd_cs_n,
  output logic        sd_sclk,
  output logic        sd_mosi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t     state_q,   state_d;
  logic [2:0] bitcnt_q,  bitcnt_d;
  logic [7:0] divcnt_q,  divcnt_d;
  logic [7:0] tx_q,      tx_d;
  logic [7:0] rx_sh_q,   rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] div_q,     div_d;
  logic       done_q,    done_d;
  logic       sclk_q,    sclk_d;

  logic wr_en, rd_en, data_wr, data_rd, div_wr, busy;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:8];

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign data_wr = wr_en & (address == 2'd0);
  assign data_rd = rd_en & (address == 2'd0);
  assign div_wr  = wr_en & (address == 2'd2);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    divcnt_d  = divcnt_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    div_d     = div_q;
    done_d    = done_q;
    sclk_d    = sclk_q;

    // The clear comes first, so completion further down overrides it.
    if (data_rd || data_wr) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (div_wr) div_d = writedata[7:0];
        if (data_wr) begin
          tx_d     = writedata[7:0];
          bitcnt_d = 3'd7;
          divcnt_d = div_q;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (divcnt_q != 8'd0) begin
          divcnt_d = divcnt_q - 8'd1;
        end else begin
          sclk_d   = 1'b1;
          rx_sh_d  = {rx_sh_q[6:0], sd_miso};
          divcnt_d = div_q;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (divcnt_q != 8'd0) begin
          divcnt_d = divcnt_q - 8'd1;
        end else if (bitcnt_q != 3'd0) begin
          sclk_d   = 1'b0;
          tx_d     = {tx_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q - 3'd1;
          divcnt_d = div_q;
          state_d  = LOW;
        end else begin
          // The eighth bit was captured on the last rising edge, so rx_sh_q
          // already holds the whole byte.
          sclk_d    = 1'b0;
          rx_byte_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        sclk_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      divcnt_q  <= 8'd0;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      div_q     <= DIV_RESET;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      divcnt_q  <= divcnt_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      div_q     <= div_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
    end
  end

  // tx_q[7] is always the bit currently on the wire. It is loaded at the
  // start write and shifted only on falling SCLK edges. MOSI idles high.
  assign sd_mosi = busy ? tx_q[7] : 1'b1;
  assign sd_sclk = sclk_q;
  assign sd_cs_n = sd_ncs_in;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {24'd0, rx_byte_q};
      2'd1:    readdata = {30'd0, done_q, busy};
      2'd2:    readdata = {24'd0, div_q};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_shifter.sv
module tb_sd_spi_shifter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sd_ncs_in = 1'b1;
  logic        sd_miso;
  logic        sd_cs_n;
  logic        sd_sclk;
  logic        sd_mosi;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  sd_spi_shifter #(.DIV_RESET(8'd124)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .sd_ncs_in(sd_ncs_in), .sd_miso(sd_miso), .sd_cs_n(sd_cs_n),
    .sd_sclk(sd_sclk), .sd_mosi(sd_mosi)
  );

  // ---------------- SPI mode-0 slave model ----------------
  // The slave presents its MSB before the first rising edge and moves to the
  // next bit on each falling edge. It records MOSI at every rising edge.
  logic [7:0] slave_byte = 8'h00;
  logic [3:0] fall_cnt = 4'd0;
  logic       mosi_seen[$];

  always @(negedge sd_sclk) fall_cnt = fall_cnt + 4'd1;
  always @(posedge sd_sclk) mosi_seen.push_back(sd_mosi);
  assign sd_miso = fall_cnt[3] ? 1'b1 : slave_byte[3'd7 - fall_cnt[2:0]];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  // Starts a transfer and polls STATUS without a bus access. It counts the
  // cycles with busy high and the SCLK runs whose length differs from div+1.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl,
                          input logic [7:0] dv, output int busy_cyc,
                          output int run_bad);
    int   run;
    logic prev;
    slave_byte = sl; fall_cnt = 4'd0; mosi_seen.delete();
    bus_write(2'd0, {24'd0, tx});
    busy_cyc = 0; run_bad = 0; run = 0; prev = 1'b0;
    address = 2'd1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (sd_sclk != prev) begin
        if (run != int'(dv) + 1) run_bad++;
        run = 1; prev = sd_sclk;
      end else begin
        run++;
      end
      if (readdata[0] == 1'b0) break;
      busy_cyc++;
    end
  endtask

  // Reference: the 8 MOSI bits seen at rising edges are tx, MSB first.
  task automatic check_mosi(input logic [7:0] tx, input string tag);
    logic exp_bits[$];
    int   bad;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(tx[i]);
    check({tag, "_mosi_count"}, mosi_seen.size(), 8);
    bad = 0;
    foreach (exp_bits[i])
      if (i >= mosi_seen.size() || mosi_seen[i] !== exp_bits[i]) bad++;
    check({tag, "_mosi_bits"}, bad, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] tx;
    logic [7:0] sl;
    logic [7:0] div;
    logic [7:0] exp_rx;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rd;
    int          bc, rb, c0;
    logic [7:0]  tx, sl, dv;

    vecs[0] = '{8'hA5, 8'h3C, 8'd0, 8'h3C, 16};
    vecs[1] = '{8'hFF, 8'h00, 8'd3, 8'h00, 64};
    vecs[2] = '{8'h00, 8'hFF, 8'd2, 8'hFF, 48};
    vecs[3] = '{8'h81, 8'h7E, 8'd1, 8'h7E, 32};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, rd); check("rst_status", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_div", rd, 32'd124);
    bus_read(2'd0, rd); check("rst_data", rd, 32'd0);
    check("rst_sclk", sd_sclk, 1'b0);
    check("rst_mosi", sd_mosi, 1'b1);
    sd_ncs_in = 1'b0; #1 check("cs_follow_low", sd_cs_n, 1'b0);
    sd_ncs_in = 1'b1; #1 check("cs_follow_high", sd_cs_n, 1'b1);

    // ---- table-driven byte exchanges ----
    foreach (vecs[k]) begin
      bus_write(2'd2, {24'd0, vecs[k].div});
      bus_read(2'd2, rd); check("vec_div", rd, {24'd0, vecs[k].div});
      run_xfer(vecs[k].tx, vecs[k].sl, vecs[k].div, bc, rb);
      check("vec_busy_cycles", bc, vecs[k].exp_busy);
      check("vec_sclk_halfperiod", rb, 0);
      check_mosi(vecs[k].tx, "vec");
      check("vec_idle_mosi", sd_mosi, 1'b1);
      bus_read(2'd1, rd); check("vec_status_done", rd, 32'd2);
      bus_read(2'd0, rd); check("vec_rx", rd, {24'd0, vecs[k].exp_rx});
      bus_read(2'd1, rd); check("vec_status_clr", rd, 32'd0);
      bus_read(2'd0, rd); check("vec_rx_hold", rd, {24'd0, vecs[k].exp_rx});
    end

    // ---- randomized exchanges against the reference model ----
    for (int n = 0; n < 12; n++) begin
      tx = 8'($urandom_range(0, 255));
      sl = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(0, 3));
      bus_write(2'd2, {24'd0, dv});
      exp_q.push_back(sl);
      run_xfer(tx, sl, dv, bc, rb);
      check("rnd_busy_cycles", bc, 16 * (int'(dv) + 1));
      check("rnd_sclk_halfperiod", rb, 0);
      check_mosi(tx, "rnd");
      bus_read(2'd1, rd); check("rnd_status_done", rd, 32'd2);
      bus_read(2'd0, rd); check("rnd_rx", rd, {24'd0, exp_q.pop_front()});
    end

    // ---- busy protection: DATA and DIV writes during a transfer ----
    bus_write(2'd2, 32'd1);
    slave_byte = 8'h5A; fall_cnt = 4'd0; mosi_seen.delete();
    bus_write(2'd0, 32'h81);
    c0 = cyc;
    repeat (3) @(posedge clk);
    bus_write(2'd0, 32'h00);
    bus_write(2'd2, 32'd9);
    address = 2'd1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (readdata[0] == 1'b0) break;
    end
    check("prot_busy_cycles", cyc - c0, 32);
    check_mosi(8'h81, "prot");
    bus_read(2'd2, rd); check("prot_div_kept", rd, 32'd1);
    bus_read(2'd1, rd); check("prot_status_done", rd, 32'd2);

    // ---- done cleared by a DATA write; done race at completion ----
    bus_write(2'd2, 32'd0);
    slave_byte = 8'h96; fall_cnt = 4'd0; mosi_seen.delete();
    bus_write(2'd0, 32'h3C);                 // edge N
    bus_read(2'd1, rd); check("race_busy_done_clr", rd, 32'd1);     // N+1
    bus_read(2'd0, rd); check("race_rx_held", rd, 32'h5A);          // N+2
    repeat (13) @(posedge clk);              // edge N+15
    bus_read(2'd0, rd);                      // accepted at N+16, completion
    bus_read(2'd1, rd); check("race_done_wins", rd, 32'd2);
    bus_read(2'd0, rd); check("race_rx", rd, 32'h96);
    bus_read(2'd1, rd); check("race_done_clr", rd, 32'd0);

    // ---- reset in the middle of a transfer ----
    bus_write(2'd2, 32'd1);
    slave_byte = 8'hC3; fall_cnt = 4'd0; mosi_seen.delete();
    bus_write(2'd0, 32'h5A);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fall_cnt == 4'd4 && sd_sclk) break;
    end
    check("mid_sclk_high", sd_sclk, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sclk", sd_sclk, 1'b0);
    check("mid_rst_mosi", sd_mosi, 1'b1);
    address = 2'd1; #1 check("mid_rst_status", readdata, 32'd0);
    address = 2'd0; #1 check("mid_rst_rx", readdata, 32'd0);
    address = 2'd2; #1 check("mid_rst_div", readdata, 32'd124);
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(2'd2, 32'd0);
    run_xfer(8'hE7, 8'h18, 8'd0, bc, rb);
    check("post_rst_busy_cycles", bc, 16);
    check_mosi(8'hE7, "post_rst");
    bus_read(2'd0, rd); check("post_rst_rx", rd, 32'h18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
